// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
// MISALIGN_TRAP_EN selects whether the misalignment helper is used by the top.
package data_mem_responder_pkg;

    typedef enum logic [2:0] {
        LOAD_BYTE          = 3'b000,
        LOAD_HALF          = 3'b001,
        LOAD_WORD          = 3'b010,
        LOAD_BYTE_UNSIGNED = 3'b100,
        LOAD_HALF_UNSIGNED = 3'b101
    } Load_Type_Case;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } Store_Type_Case;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } Mem_Resp_State;

    localparam int WAIT_CNT_W = 4;

    // Store funct3 values outside SB/SH behave as SW.
    function automatic logic [3:0] store_byte_en(input logic [2:0] funct3, input logic [1:0] offset);
        logic [3:0] be;
        case (funct3)
            SB:      be = 4'b0001 << offset;
            SH:      be = offset[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic is_misaligned(input logic we, input logic [2:0] funct3, input logic [1:0] offset);
        logic mis;
        if (we) begin
            case (funct3)
                SB:      mis = 1'b0;
                SH:      mis = offset[0];
                default: mis = (offset != 2'b00);
            endcase
        end else begin
            case (funct3)
                LOAD_HALF, LOAD_HALF_UNSIGNED: mis = offset[0];
                LOAD_WORD:                     mis = (offset != 2'b00);
                default:                       mis = 1'b0;
            endcase
        end
        return mis;
    endfunction

endpackage

// File: rtl/data_mem_responder_load_extend.sv
// Lane select and sign/zero extension of a loaded RAM word.
// Undefined load funct3 values return the whole word.
module data_mem_load_extend
    import data_mem_responder_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_offset)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        o_data = i_word;
        case (i_funct3)
            LOAD_BYTE:          o_data = {{24{w_byte[7]}}, w_byte};
            LOAD_BYTE_UNSIGNED: o_data = {24'h0, w_byte};
            LOAD_HALF:          o_data = {{16{w_half[15]}}, w_half};
            LOAD_HALF_UNSIGNED: o_data = {16'h0, w_half};
            default:            o_data = i_word;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: valid/ready request, programmable wait states, byte-lane RAM.
// Define MISALIGN_TRAP_EN to report misaligned accesses on RespErr instead of aligning them.
//
// state | meaning
// IDLE  | ReqReady high, waiting for a request
// WAIT  | wait-state countdown before the access
// RESP  | registered response held until RespReady
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWE,
    input  logic [2:0]  ReqFunct3,
    input  logic [31:0] ReqAddress,
    input  logic [31:0] ReqWD,
    output logic        RespValid,
    input  logic        RespReady,
    output logic [31:0] RespRD,
    output logic        RespErr
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_STATES == 0) ? '0 : WAIT_CNT_W'(WAIT_STATES - 1);

    Mem_Resp_State           r_state, w_next_state;
    logic [WAIT_CNT_W-1:0]   r_wait_cnt;
    logic                    r_we;
    logic [2:0]              r_funct3;
    logic [IDX_W+1:0]        r_addr;
    logic [31:0]             r_wd;
    logic [31:0]             r_resp_rd;
    logic                    r_resp_err;
    logic [31:0]             r_mem [DEPTH_WORDS];

    logic                    w_req_fire;
    logic                    w_enter_resp;
    logic                    w_op_we;
    logic [2:0]              w_op_funct3;
    logic [IDX_W+1:0]        w_op_addr;
    logic [31:0]             w_op_wd;
    logic [IDX_W-1:0]        w_idx;
    logic [1:0]              w_off;
    logic                    w_fault;
    logic [3:0]              w_be;
    logic [31:0]             w_wdata;
    logic [31:0]             w_rd_word;
    logic [31:0]             w_ld_data;
    logic                    w_unused_addr;

    assign w_unused_addr = ^ReqAddress[31:IDX_W+2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        ReqReady     = 1'b0;
        RespValid    = 1'b0;
        case (r_state)
            IDLE: begin
                ReqReady = 1'b1;
                if (ReqValid) w_next_state = (WAIT_STATES == 0) ? RESP : WAIT;
            end
            WAIT: begin
                if (r_wait_cnt == '0) w_next_state = RESP;
            end
            RESP: begin
                RespValid = 1'b1;
                if (RespReady) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_req_fire   = ReqValid && (r_state == IDLE);
    assign w_enter_resp = (w_next_state == RESP) && (r_state != RESP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= '0;
            r_we       <= 1'b0;
            r_funct3   <= '0;
            r_addr     <= '0;
            r_wd       <= '0;
        end else begin
            if (w_req_fire) begin
                r_wait_cnt <= WAIT_LOAD;
                r_we       <= ReqWE;
                r_funct3   <= ReqFunct3;
                r_addr     <= ReqAddress[IDX_W+1:0];
                r_wd       <= ReqWD;
            end else if (r_state == WAIT && r_wait_cnt != '0) begin
                r_wait_cnt <= r_wait_cnt - 1'b1;
            end
        end
    end

    // With zero wait states the access happens on the accepting edge, before capture.
    always_comb begin
        if (r_state == IDLE) begin
            w_op_we     = ReqWE;
            w_op_funct3 = ReqFunct3;
            w_op_addr   = ReqAddress[IDX_W+1:0];
            w_op_wd     = ReqWD;
        end else begin
            w_op_we     = r_we;
            w_op_funct3 = r_funct3;
            w_op_addr   = r_addr;
            w_op_wd     = r_wd;
        end
    end

    assign w_idx = w_op_addr[IDX_W+1:2];
    assign w_off = w_op_addr[1:0];

`ifdef MISALIGN_TRAP_EN
    assign w_fault = is_misaligned(w_op_we, w_op_funct3, w_off);
`else
    assign w_fault = 1'b0;
`endif

    assign w_be = store_byte_en(w_op_funct3, w_off);

    always_comb begin
        case (w_op_funct3)
            SB:      w_wdata = {4{w_op_wd[7:0]}};
            SH:      w_wdata = {2{w_op_wd[15:0]}};
            default: w_wdata = w_op_wd;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_enter_resp && w_op_we && !w_fault) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

    assign w_rd_word = r_mem[w_idx];

    data_mem_load_extend u_load_extend (
        .i_word   (w_rd_word),
        .i_offset (w_off),
        .i_funct3 (w_op_funct3),
        .o_data   (w_ld_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_resp_rd  <= '0;
            r_resp_err <= 1'b0;
        end else if (w_enter_resp) begin
            r_resp_rd  <= (w_op_we || w_fault) ? 32'h0 : w_ld_data;
            r_resp_err <= w_fault;
        end
    end

    assign RespRD  = r_resp_rd;
    assign RespErr = r_resp_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed table, multi-cycle corner cases, random vs model.
module tb_data_mem_responder;

    localparam int DEPTH = 64;
    localparam int WS    = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ReqValid = 1'b0;
    logic        ReqReady;
    logic        ReqWE = 1'b0;
    logic [2:0]  ReqFunct3 = 3'b0;
    logic [31:0] ReqAddress = 32'h0;
    logic [31:0] ReqWD = 32'h0;
    logic        RespValid;
    logic        RespReady = 1'b1;
    logic [31:0] RespRD;
    logic        RespErr;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ReqValid   (ReqValid),
        .ReqReady   (ReqReady),
        .ReqWE      (ReqWE),
        .ReqFunct3  (ReqFunct3),
        .ReqAddress (ReqAddress),
        .ReqWD      (ReqWD),
        .RespValid  (RespValid),
        .RespReady  (RespReady),
        .RespRD     (RespRD),
        .RespErr    (RespErr)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] mdl [DEPTH];

    typedef struct {
        string       nm;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input logic err);
        vec_t v;
        v.nm = nm; v.we = we; v.f3 = f3; v.addr = a; v.wd = wd; v.exp_rd = rd; v.exp_err = err;
        tbl.push_back(v);
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic logic m_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
        if (we) begin
            if (f3 == 3'd0) return 1'b0;
            if (f3 == 3'd1) return a[0];
            return a[1:0] != 2'd0;
        end
        if (f3 == 3'd1 || f3 == 3'd5) return a[0];
        if (f3 == 3'd2) return a[1:0] != 2'd0;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (8 * int'(a[1:0])));
        h = 16'(w >> (16 * int'(a[1])));
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd4:    return {24'h0, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd5:    return {16'h0, h};
            default: return w;
        endcase
    endfunction

    task automatic m_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int i;
        i = widx(a);
        case (f3)
            3'd0:    mdl[i][8*int'(a[1:0]) +: 8] = wd[7:0];
            3'd1:    mdl[i][16*int'(a[1]) +: 16] = wd[15:0];
            default: mdl[i] = wd;
        endcase
    endtask

    // lat counts the accepting edge as 1; RespValid is expected after 1+WS edges.
    task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int lat);
        @(negedge clk);
        ReqValid = 1'b1; ReqWE = we; ReqFunct3 = f3; ReqAddress = a; ReqWD = wd;
        @(posedge clk); #1;
        ReqValid = 1'b0;
        lat = 1;
        while (RespValid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rd  = RespRD;
        err = RespErr;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat;
        logic        trap;
`ifdef MISALIGN_TRAP_EN
        trap = 1'b1;
`else
        trap = 1'b0;
`endif

        #12;
        chk("rst_req_ready", {31'h0, ReqReady}, 32'h1);
        chk("rst_resp_valid", {31'h0, RespValid}, 32'h0);
        chk("rst_resp_rd", RespRD, 32'h0);
        chk("rst_resp_err", {31'h0, RespErr}, 32'h0);
        @(negedge clk); reset_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) begin
            do_txn(1'b1, 3'd2, 32'(i * 4), 32'(i) * 32'h01010101, rd, err, lat);
            mdl[i] = 32'(i) * 32'h01010101;
        end

        add("sw_10",     1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        add("lw_10",     0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        add("sb_13",     1, 3'd0, 32'h13, 32'h00000080, 32'h0, 0);
        add("lw_10_sb",  0, 3'd2, 32'h10, 32'h0, 32'h80ADBEEF, 0);
        add("lb_13",     0, 3'd0, 32'h13, 32'h0, 32'hFFFFFF80, 0);
        add("lbu_13",    0, 3'd4, 32'h13, 32'h0, 32'h00000080, 0);
        add("sh_22",     1, 3'd1, 32'h22, 32'h00008001, 32'h0, 0);
        add("lh_22",     0, 3'd1, 32'h22, 32'h0, 32'hFFFF8001, 0);
        add("lhu_22",    0, 3'd5, 32'h22, 32'h0, 32'h00008001, 0);
        add("lw_20",     0, 3'd2, 32'h20, 32'h0, 32'h80010808, 0);
        add("lw_11_mis", 0, 3'd2, 32'h11, 32'h0, trap ? 32'h0 : 32'h80ADBEEF, trap);
        add("lw_wrap",   0, 3'd2, 32'(4 * DEPTH + 'h10), 32'h0, 32'h80ADBEEF, 0);
        add("sw_30",     1, 3'd2, 32'h30, 32'h7F00017F, 32'h0, 0);
        add("lb_30",     0, 3'd0, 32'h30, 32'h0, 32'h0000007F, 0);
        add("lb_31",     0, 3'd0, 32'h31, 32'h0, 32'h00000001, 0);
        add("lh_32",     0, 3'd1, 32'h32, 32'h0, 32'h00007F00, 0);
        add("ld_f3_011", 0, 3'd3, 32'h30, 32'h0, 32'h7F00017F, 0);
        add("ld_f3_110", 0, 3'd6, 32'h33, 32'h0, 32'h7F00017F, 0);
        add("st_f3_111", 1, 3'd7, 32'h34, 32'hCAFEF00D, 32'h0, 0);
        add("lw_34",     0, 3'd2, 32'h34, 32'h0, 32'hCAFEF00D, 0);
        add("sh_37_mis", 1, 3'd1, 32'h37, 32'h00001234, 32'h0, trap);
        add("lw_34_sh",  0, 3'd2, 32'h34, 32'h0, trap ? 32'hCAFEF00D : 32'h1234F00D, 0);
        add("sb_hiaddr", 1, 3'd0, 32'hFFFFFF35, 32'h0000005A, 32'h0, 0);
        add("lw_34_sb",  0, 3'd2, 32'h34, 32'h0, trap ? 32'hCAFE5A0D : 32'h12345A0D, 0);
        add("lb_35",     0, 3'd0, 32'h35, 32'h0, 32'h0000005A, 0);

        foreach (tbl[k]) begin
            do_txn(tbl[k].we, tbl[k].f3, tbl[k].addr, tbl[k].wd, rd, err, lat);
            chk({tbl[k].nm, "_rd"}, rd, tbl[k].exp_rd);
            chk({tbl[k].nm, "_err"}, {31'h0, err}, {31'h0, tbl[k].exp_err});
            chk({tbl[k].nm, "_lat"}, 32'(lat), 32'(1 + WS));
            if (tbl[k].we && !m_fault(1'b1, tbl[k].f3, tbl[k].addr)) m_store(tbl[k].f3, tbl[k].addr, tbl[k].wd);
        end

        // Response back-pressure: outputs must hold while RespReady is low.
        RespReady = 1'b0;
        @(negedge clk);
        ReqValid = 1'b1; ReqWE = 1'b0; ReqFunct3 = 3'd2; ReqAddress = 32'h10;
        @(posedge clk); #1;
        ReqValid = 1'b0;
        lat = 1;
        while (RespValid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("stall_lat", 32'(lat), 32'(1 + WS));
        for (int c = 0; c < 5; c++) begin
            chk("stall_valid", {31'h0, RespValid}, 32'h1);
            chk("stall_rd", RespRD, 32'h80ADBEEF);
            chk("stall_req_ready", {31'h0, ReqReady}, 32'h0);
            @(posedge clk); #1;
        end
        @(negedge clk); RespReady = 1'b1;
        @(posedge clk); #1;
        chk("stall_release_valid", {31'h0, RespValid}, 32'h0);
        chk("stall_release_ready", {31'h0, ReqReady}, 32'h1);

        // Reset during WAIT discards the pending store.
        @(negedge clk);
        ReqValid = 1'b1; ReqWE = 1'b1; ReqFunct3 = 3'd2; ReqAddress = 32'h40; ReqWD = 32'h12345678;
        @(posedge clk); #1;
        ReqValid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("wrst_valid", {31'h0, RespValid}, 32'h0);
        chk("wrst_ready", {31'h0, ReqReady}, 32'h1);
        chk("wrst_rd", RespRD, 32'h0);
        chk("wrst_err", {31'h0, RespErr}, 32'h0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        do_txn(1'b0, 3'd2, 32'h40, 32'h0, rd, err, lat);
        chk("wrst_lw_40", rd, 32'h10101010);

        for (int n = 0; n < 300; n++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] a, wd, erd;
            logic        eerr;
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            wd = $urandom;
            eerr = m_fault(we, f3, a);
            erd  = (we || eerr) ? 32'h0 : m_load(mdl[widx(a)], f3, a);
            do_txn(we, f3, a, wd, rd, err, lat);
            chk("rand_rd", rd, erd);
            chk("rand_err", {31'h0, err}, {31'h0, eerr});
            chk("rand_lat", 32'(lat), 32'(1 + WS));
            if (we && !eerr) m_store(f3, a, wd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
